// File: rtl/serial_pkg.sv
// Shared definitions for the serial echo path: transform modes, TX FSM states
// and the word transform used on enqueue.
package serial_pkg;

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_MSB_INV = 2'd1;
  localparam logic [1:0] MODE_ALL_INV = 2'd2;
  localparam logic [1:0] MODE_DROP    = 2'd3;

  localparam int unsigned ECHO_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE
  } tx_state_t;

  // Word sits in the low w bits of a zero-extended vector; the MSB (bit w-1)
  // is never altered, only the bits below it may be inverted.
  function automatic logic [ECHO_MAX_W-1:0] echo_xform(
    input logic [ECHO_MAX_W-1:0] word,
    input logic [1:0]            mode,
    input int unsigned           w
  );
    logic [ECHO_MAX_W-1:0] mask;
    logic                  msb;
    mask = '0;
    for (int i = 0; i < int'(ECHO_MAX_W); i++) begin
      if (i < int'(w) - 1) mask[i] = 1'b1;
    end
    msb = word[w-1];
    case (mode)
      MODE_MSB_INV: echo_xform = msb ? (word ^ mask) : word;
      MODE_ALL_INV: echo_xform = word ^ mask;
      default:      echo_xform = word;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy counter drives full/empty so the
// pointers can wrap freely. A push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/serial_echo_ctrl.sv
// Echo controller: detects end of reception, transforms and queues the word,
// then hands queued words to the transmitter with a busy-acknowledge timeout.
module serial_echo_ctrl
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int LVL_W       = $clog2(DEPTH + 1),
  localparam int TW          = $clog2(BUSY_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_status,
  input  logic              tx_status,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              tx_timeout
);

  logic                  rx_q;
  logic                  rx_fall;
  logic                  push_req;
  logic                  pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_W-1:0]     fifo_rdata, fifo_wdata;
  logic [ECHO_MAX_W-1:0] xin, xout;
  logic                  unused_xform_bits;

  tx_state_t         state_q, state_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              overflow_q, overflow_d;
  logic              tx_timeout_q, tx_timeout_d;

  assign rx_fall  = rx_q & ~rx_status;
  assign push_req = rx_fall & (mode != MODE_DROP);

  always_comb begin
    xin             = '0;
    xin[DATA_W-1:0] = rx_data;
  end
  assign xout              = echo_xform(xin, mode, DATA_W);
  assign fifo_wdata        = xout[DATA_W-1:0];
  assign unused_xform_bits = ^xout;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    timer_d      = timer_q;
    tx_timeout_d = tx_timeout_q;
    pop          = 1'b0;
    overflow_d   = overflow_q | (push_req & fifo_full & ~pop);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && tx_status) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = fifo_rdata;
          timer_d   = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_status) begin
          state_d = ST_WAIT_IDLE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never went busy; treat the word as sent and move on.
          tx_timeout_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (tx_status) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    overflow_d = overflow_q | (push_req & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q         <= 1'b0;
      state_q      <= ST_IDLE;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      rx_q         <= rx_status;
      state_q      <= state_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;

endmodule
